// File: rtl/sd_pkg.sv
// sd_pkg: shared sigma-delta scaling so the modulator bench and decimator agree.
package sd_pkg;
    localparam int LOG2R_DEF = 4;
    function automatic int outw_f(input int log2r);
        return 2 * log2r + 1;
    endfunction
endpackage

// File: rtl/sinc_comb_stage.sv
// sinc_comb_stage: one CIC comb, q = d - d delayed by one strobe.
module sinc_comb_stage #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] c_d;
    assign q = d - c_d;
    always_ff @(posedge clk or posedge reset)
        if (reset) c_d <= '0;
        else if (en) c_d <= d;
endmodule

// File: rtl/sd_sinc2_decimator.sv
// sd_sinc2_decimator: sinc2 CIC decimator turning a 1-bit stream into a ones-density estimate.
module sd_sinc2_decimator
    import sd_pkg::*;
#(
    parameter  int LOG2R = LOG2R_DEF,
    localparam int OUTW  = outw_f(LOG2R)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bs_in,
    input  logic            bs_en,
    output logic [OUTW-1:0] data_out,
    output logic            data_valid,
    output logic            settled
);
    logic [OUTW-1:0] i1, i2, i1n, i2n, c1, c2;
    logic [LOG2R-1:0] cnt;
    logic stb, first_done;
    assign i1n = i1 + OUTW'(bs_in);
    assign i2n = i2 + i1n;
    assign stb = bs_en && (cnt == '1);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            i1 <= '0;
            i2 <= '0;
            cnt <= '0;
        end else if (bs_en) begin
            i1 <= i1n;
            i2 <= i2n;
            cnt <= cnt + 1'b1;
        end
    sinc_comb_stage #(.W(OUTW)) u_comb2 (.clk(clk), .reset(reset), .en(stb), .d(i2n), .q(c1));
    sinc_comb_stage #(.W(OUTW)) u_comb1 (.clk(clk), .reset(reset), .en(stb), .d(c1), .q(c2));
    // the first output after reset carries the integrator start-up transient
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data_out <= '0;
            data_valid <= 1'b0;
            settled <= 1'b0;
            first_done <= 1'b0;
        end else begin
            data_valid <= stb;
            if (stb) begin
                data_out <= c2;
                first_done <= 1'b1;
                settled <= settled | first_done;
            end
        end
endmodule

// File: tb/tb_sd_sinc2_decimator.sv
// tb_sd_sinc2_decimator: checks the decimator against a wrap-free CIC sum model plus literal sequences.
module tb_sd_sinc2_decimator;
    localparam int LOG2R = 4;
    localparam int R = 1 << LOG2R;
    localparam int OUTW = 2 * LOG2R + 1;
    logic clk = 1'b0, reset = 1'b0, bs_in = 1'b0, bs_en = 1'b0;
    logic [OUTW-1:0] data_out;
    logic data_valid, settled;
    int n_cmp = 0, n_bad = 0;
    int got[$];
    int got_settled[$];
    sd_sinc2_decimator #(.LOG2R(LOG2R)) dut (
        .clk(clk), .reset(reset), .bs_in(bs_in), .bs_en(bs_en),
        .data_out(data_out), .data_valid(data_valid), .settled(settled)
    );
    always #5 clk = ~clk;
    // model: S1(n) ones count, S2(n) running sum of S1; output k = S2(kR) - 2 S2((k-1)R) + S2((k-2)R)
    longint m_s1, m_s2, m_w1, m_w2, s1n, s2n;
    int m_n, m_outs;
    logic bnd, exp_valid, exp_settled;
    logic [OUTW-1:0] exp_data;
    always_comb begin
        s1n = m_s1 + longint'(bs_in);
        s2n = m_s2 + s1n;
        bnd = bs_en && ((m_n + 1) % R == 0);
    end
    always @(posedge clk or posedge reset)
        if (reset) begin
            m_s1 <= 0; m_s2 <= 0; m_w1 <= 0; m_w2 <= 0; m_n <= 0; m_outs <= 0;
            exp_valid <= 1'b0; exp_data <= '0; exp_settled <= 1'b0;
        end else begin
            exp_valid <= bnd;
            if (bs_en) begin
                m_s1 <= s1n; m_s2 <= s2n; m_n <= m_n + 1;
            end
            if (bnd) begin
                exp_data <= OUTW'(s2n - 2 * m_w1 + m_w2);
                m_w1 <= s2n; m_w2 <= m_w1; m_outs <= m_outs + 1;
                exp_settled <= exp_settled | (m_outs >= 1);
            end
        end
    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("model_valid", longint'(data_valid), longint'(exp_valid));
        chk("model_data", longint'(data_out), longint'(exp_data));
        chk("model_settled", longint'(settled), longint'(exp_settled));
        if (data_valid) begin
            got.push_back(int'(data_out));
            got_settled.push_back(int'(settled));
        end
    end
    task automatic step(input logic b, input logic en);
        @(posedge clk);
        #2 bs_in = b; bs_en = en;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("rst_data", longint'(data_out), 0);
        chk("rst_valid", longint'(data_valid), 0);
        chk("rst_settled", longint'(settled), 0);
        @(posedge clk);
        #3 reset = 1'b0; bs_en = 1'b0;
        got.delete(); got_settled.delete();
    endtask
    initial begin
        int gaps[R];
        do_reset();
        for (int i = 0; i < R - 1; i++) step(1'b1, 1'b1);
        idle(2);
        chk("no_pulse_15", got.size(), 0);
        for (int i = 0; i < 2 * R + 1; i++) step(1'b1, 1'b1);
        idle(2);
        chk("ones_count", got.size(), 3);
        chk("ones_out1", got[0], 136);
        chk("ones_out2", got[1], 256);
        chk("ones_out3", got[2], 256);
        chk("ones_settled1", got_settled[0], 0);
        chk("ones_settled2", got_settled[1], 1);
        do_reset();
        for (int i = 0; i < 3 * R; i++) step(1'b0, 1'b1);
        idle(2);
        chk("zeros_count", got.size(), 3);
        chk("zeros_out2", got[1], 0);
        chk("zeros_settled", longint'(settled), 1);
        do_reset();
        for (int i = 0; i < 100 * R; i++) step(i % 2 == 0, 1'b1);
        idle(2);
        chk("alt_count", got.size(), 100);
        chk("alt_out1", got[0], 72);
        chk("alt_out2", got[1], 128);
        chk("alt_out100", got[99], 128);
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < R; i++) gaps[i] = 0;
            for (int g = 0; g < 7; g++) gaps[$urandom_range(0, R - 2)]++;
            for (int s = 0; s < R; s++) begin
                step(1'b1, 1'b1);
                for (int g = 0; g < gaps[s]; g++) step(1'($urandom), 1'b0);
            end
        end
        idle(2);
        chk("gap_count", got.size(), 3);
        chk("gap_out1", got[0], 136);
        chk("gap_out2", got[1], 256);
        chk("gap_out3", got[2], 256);
        do_reset();
        for (int i = 0; i < 2 * R + 8; i++) step(1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 2 * R; i++) step(1'b1, 1'b1);
        idle(2);
        chk("mid_count", got.size(), 2);
        chk("mid_out1", got[0], 136);
        chk("mid_out2", got[1], 256);
        chk("mid_settled1", got_settled[0], 0);
        chk("mid_settled2", got_settled[1], 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_sinc2_decimator.md
Name: sd_sinc2_decimator

Overview:
- Downstream consumer of the sigma-delta modulator's 1-bit stream.
- Second-order CIC (sinc2) decimator with ratio R = 2^LOG2R: two integrators at bit rate, one decimation strobe, two combs at output rate.
- Produces an unsigned multi-bit estimate of the bitstream's ones-density with a one-cycle valid pulse, for readback and characterisation of the modulator.

Parameters:
- LOG2R, 4, log2 of decimation ratio R (R = 16 by default); legal range 1..12.
- OUTW, 2*LOG2R+1, derived localparam: width of all integrator, comb and output registers (holds 0..R^2).

Ports:
- clk  input  1  system clock; bitstream is sampled here.
- reset  input  1  asynchronous, active-high; clears all state.
- bs_in  input  1  modulator bitstream bit; 1 counts as +1, 0 counts as 0.
- bs_en  input  1  sample qualifier; state advances only on cycles with bs_en=1.
- data_out  output  OUTW  decimated result, unsigned, full scale R^2.
- data_valid  output  1  one-cycle pulse when data_out updates.
- settled  output  1  high once warm-up outputs have been produced.

Behaviour:
- Reset (async, active-high) clears i1, i2, decimation counter, comb delays c2d and c1d, data_out, data_valid, settled and the warm-up count, all to 0. Reset asserted mid-window discards the partial window; counting restarts at sample 0 after release.
- Integrators, all modulo 2^OUTW, with wrap intended and no saturation. On each clk edge with bs_en=1:
  - i1 <= i1 + bs_in
  - i2 <= i2 + (i1 + bs_in), i.e. i2 accumulates the updated i1.
- Decimation counter: OUTW-agnostic, LOG2R bits, 0..R-1, increments on bs_en and wraps R-1 -> 0.
- Strobe condition: bs_en=1 and counter==R-1 (the R-th sample of the window). On the strobe edge, using the post-update i2 value (i2n):
  - c1 = i2n - c2d
  - data_out <= c1 - c1d
  - c2d <= i2n
  - c1d <= c1
  - data_valid <= 1
- data_valid is 0 on every other cycle. Latency is 1 clk from the R-th qualified sample to the data_valid pulse. data_out holds between pulses.
- bs_en=0 freezes integrators, counter and combs; gaps inside a window do not alter the result.
- settled: 0 after reset, set on the edge producing the 2nd output after reset, then sticky until reset. The first output is a transient and must be ignored by consumers.
- Comb arithmetic is modulo 2^OUTW. The true result is bounded by R^2 < 2^OUTW, so wrap in the integrators is always cancelled.
- No backpressure: the consumer must capture on data_valid.

Decomposition:
- Shared package sd_pkg holds the LOG2R default and the OUTW derivation function, so the modulator bench and the decimator agree on scaling.
- One natural sub-module: sinc_comb_stage (register c_d plus subtractor, enabled by the strobe), instantiated twice.
- The integrators and the counter stay in the top.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> all outputs 0 immediately; data_valid stays 0 for 15 bs_en cycles after release.
- All-ones, LOG2R=4, bs_en=1: outputs 136, 256, 256, ... at cycles 16, 32, 48 (+1 clk); settled rises with the 256 at output 2.
- All-zeros: every output is 0; settled rises at output 2.
- Alternating 1,0 starting with 1: steady-state output 128 from output 2 onward; run for 100 outputs with no drift, exercising integrator wrap.
- bs_en gating: all-ones with bs_en low for 7 random cycles inside each window -> same sequence 136, 256, 256; pulses are delayed by the gap count.
- Reset mid-window: all-ones, assert reset at sample 9 of window 3, release -> sequence restarts 136, 256 and settled re-qualifies.
